seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 Parameter PRESCALE, default 50000, clk cycles per digit slot (legal >=2).
REQ-003 Parameter ACTIVE_LOW, default 0, 1 inverts seg, dp and an at the pins.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 load  input  1  one-cycle strobe, capture value/dp_in into shadow register.
REQ-007 value  input  4*DIGITS  BCD/hex nibbles, digit 0 = bits [3:0] (rightmost).
REQ-008 dp_in  input  DIGITS  per-digit decimal point request.
REQ-009 hex_mode  input  1  1 = nibbles 10-15 shown as A,b,C,d,E,F; 0 = blank.
REQ-010 seg  output  7  registered segments, order a..g, a = MSB.
REQ-011 dp  output  1  registered decimal point for active digit.
REQ-012 an  output  DIGITS  registered one-hot digit enable.
REQ-013 frame_done  output  1  one-cycle pulse at each scan wrap.
REQ-014 load_ack  output  1  one-cycle pulse when shadow is committed to display.

Function
REQ-015 Encoding (active-high, before polarity) SHALL be 0:1111110 1:0110000 2:1101101 3:1111001 4:0110011 5:1011011 6:1011111 7:1110000 8:1111111 9:1111011; hex A:1110111 b:0011111 C:1001110 d:0111101 E:1001111 F:1000111.
REQ-016 Prescaler SHALL count 0..PRESCALE-1 and wrap; terminal count = tick.
REQ-017 On tick, digit index SHALL advance 0..DIGITS-1 and wrap to 0.
REQ-018 seg, dp, an SHALL update on the same edge the index changes (zero added latency); one digit slot = PRESCALE cycles exactly.
REQ-019 an SHALL have exactly one bit active at all times after reset.
REQ-020 load SHALL write value/dp_in to shadow and set pending; a second load while pending SHALL overwrite shadow (last wins), one load_ack only.
REQ-021 On the tick wrapping index DIGITS-1 -> 0: frame_done SHALL pulse; if pending, display register <= shadow, pending cleared, load_ack pulses; new data shown from digit 0 of that edge (no mid-frame tearing).
REQ-022 load coincident with the wrap tick SHALL commit that cycle's value directly, load_ack pulses on that edge, pending stays 0.
REQ-023 DIGITS=1: every tick is a wrap; frame_done pulses each tick.
REQ-024 hex_mode SHALL be sampled combinationally at output register load; changes take effect at next tick.

Reset
REQ-025 rst_n low SHALL asynchronously clear prescaler, index, shadow, pending, display register.
REQ-026 Reset outputs: an = digit 0 enabled, seg = code for 0, dp off, frame_done = 0, load_ack = 0, polarity per ACTIVE_LOW.
REQ-027 Reset mid-frame or with pending load SHALL discard the pending data; no load_ack after release.

Configuration
REQ-028 Macro SEG7_LEADING_ZERO_BLANK_EN defined: digits above the most significant non-zero nibble SHALL show blank segments (dp still per dp_in); digit 0 never blanked; all-zero value shows single "0".
REQ-029 Macro undefined: every digit SHALL display its nibble; no blanking logic synthesised.

Verification (DIGITS=4, PRESCALE=4, ACTIVE_LOW=0)
REQ-030 Reset release, no load -> an 0001,0010,0100,1000,0001 each 4 cycles; seg 1111110 every slot; frame_done every 16 cycles.
REQ-031 load value=16'h1234 mid-frame -> display unchanged until wrap; at wrap load_ack=1, digit 0 seg=0110011 ("4"), digit 3 seg=0110000 ("1").
REQ-032 value=16'h00AF, hex_mode=1 -> digit0 1000111, digit1 1110111; hex_mode=0 -> both blank 0000000.
REQ-033 With SEG7_LEADING_ZERO_BLANK_EN, value=16'h0070 -> digits 3,2 blank, digit1 1110000, digit0 1111110; without macro digits 3,2 show 1111110.
REQ-034 Loads 16'h1111 then 16'h2222 before wrap -> single load_ack, 16'h2222 displayed; load on wrap-tick cycle -> immediate commit same edge.
REQ-035 rst_n asserted mid-slot with pending load -> outputs return to REQ-026 values asynchronously; after release, no load_ack, display shows 0000.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 7-segment display scanner.
// A prescaler sets the dwell per digit. Loads are double-buffered and only
// reach the display at the frame wrap, so a frame never mixes old and new data.
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg7_scan_driver #(
  parameter int DIGITS     = 4,
  parameter int PRESCALE   = 50000,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  hex_mode,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done,
  output logic                  load_ack
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic          POL      = (ACTIVE_LOW != 0);
  localparam logic [6:0]    SEG_ZERO = 7'b1111110;

  // Nibble to segment pattern (a..g, a = MSB), active-high.
  function automatic logic [6:0] seg_encode(input logic [3:0] nib, input logic hex);
    logic [6:0] c;
    c = 7'b0000000;
    case (nib)
      4'h0: c = 7'b1111110;
      4'h1: c = 7'b0110000;
      4'h2: c = 7'b1101101;
      4'h3: c = 7'b1111001;
      4'h4: c = 7'b0110011;
      4'h5: c = 7'b1011011;
      4'h6: c = 7'b1011111;
      4'h7: c = 7'b1110000;
      4'h8: c = 7'b1111111;
      4'h9: c = 7'b1111011;
      4'hA: c = hex ? 7'b1110111 : 7'b0000000;
      4'hB: c = hex ? 7'b0011111 : 7'b0000000;
      4'hC: c = hex ? 7'b1001110 : 7'b0000000;
      4'hD: c = hex ? 7'b0111101 : 7'b0000000;
      4'hE: c = hex ? 7'b1001111 : 7'b0000000;
      4'hF: c = hex ? 7'b1000111 : 7'b0000000;
      default: c = 7'b0000000;
    endcase
    return c;
  endfunction

  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IW-1:0]             idx_q, idx_d, idx_nxt;
  logic [4*DIGITS-1:0]       sh_val_q, sh_val_d;
  logic [DIGITS-1:0]         sh_dp_q, sh_dp_d;
  logic                      pend_q, pend_d;
  logic [4*DIGITS-1:0]       disp_val_q, disp_val_d;
  logic [DIGITS-1:0]         disp_dp_q, disp_dp_d;
  logic [6:0]                seg_q, seg_d;
  logic                      dp_q, dp_d;
  logic [DIGITS-1:0]         an_q, an_d;
  logic                      frame_q, frame_d;
  logic                      ack_q, ack_d;

  logic                      tick, wrap;
  logic [DIGITS-1:0][3:0]    nib_d;
  logic [DIGITS-1:0]         blank;
  logic [6:0]                code;

  assign tick    = (cnt_q == CNT_LAST);
  assign wrap    = tick && (idx_q == IDX_LAST);
  assign idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  assign nib_d   = disp_val_d;

  // Prescaler and digit index; index steps on the terminal count.
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = tick ? idx_nxt : idx_q;
  end

  // Shadow capture and commit at frame wrap; a load on the wrap bypasses the shadow.
  always_comb begin
    sh_val_d   = sh_val_q;
    sh_dp_d    = sh_dp_q;
    pend_d     = pend_q;
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    ack_d      = 1'b0;
    if (wrap && load) begin
      disp_val_d = value;
      disp_dp_d  = dp_in;
      pend_d     = 1'b0;
      ack_d      = 1'b1;
    end else if (wrap && pend_q) begin
      disp_val_d = sh_val_q;
      disp_dp_d  = sh_dp_q;
      pend_d     = 1'b0;
      ack_d      = 1'b1;
    end else if (load) begin
      sh_val_d = value;
      sh_dp_d  = dp_in;
      pend_d   = 1'b1;
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic seen_nz;
  // Blank every digit above the most significant non-zero nibble; digit 0 always shows.
  always_comb begin
    blank   = '0;
    seen_nz = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      seen_nz  = seen_nz | (nib_d[i] != 4'd0);
      blank[i] = ~seen_nz;
    end
  end
`else
  assign blank = '0;
`endif

  // Output registers load from the next index and next display data, so pins
  // change on the very edge the index moves.
  always_comb begin
    seg_d   = seg_q;
    dp_d    = dp_q;
    an_d    = an_q;
    frame_d = wrap;
    code    = 7'b0000000;
    if (tick) begin
      code = seg_encode(nib_d[idx_d], hex_mode);
      if (blank[idx_d]) code = 7'b0000000;
      seg_d = code ^ {7{POL}};
      dp_d  = disp_dp_d[idx_d] ^ POL;
      an_d  = (DIGITS'(1) << idx_d) ^ {DIGITS{POL}};
    end
  end

  // State registers; reset shows digit 0 displaying "0".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      sh_val_q   <= '0;
      sh_dp_q    <= '0;
      pend_q     <= 1'b0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      seg_q      <= SEG_ZERO ^ {7{POL}};
      dp_q       <= POL;
      an_q       <= DIGITS'(1) ^ {DIGITS{POL}};
      frame_q    <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sh_val_q   <= sh_val_d;
      sh_dp_q    <= sh_dp_d;
      pend_q     <= pend_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      frame_q    <= frame_d;
      ack_q      <= ack_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_q;
  assign load_ack   = ack_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (DIGITS=4, PRESCALE=4, ACTIVE_LOW=0).
// Expected per-slot outputs are queued as stimulus is planned; a monitor pops
// one entry at every slot boundary and checks hold/pulse behaviour in between.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n, load, hex_mode;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp, frame_done, load_ack;
  logic [3:0]  an;

  seg7_scan_driver #(.DIGITS(4), .PRESCALE(4), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .hex_mode(hex_mode), .seg(seg), .dp(dp), .an(an),
    .frame_done(frame_done), .load_ack(load_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    logic       ack;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   tests  = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   tb_idx = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference patterns, 0..F, active-high a..g.
  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int i, input logic hx);
    logic [6:0] tbl [16];
    logic [3:0] n;
    tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
            7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
            7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    n = v[i*4 +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (i > 0 && (v >> (i*4)) == 16'h0) return 7'b0000000;
`endif
    if (n > 4'd9 && !hx) return 7'b0000000;
    return tbl[n];
  endfunction

  // Queue the next n slot boundaries showing value v.
  task automatic push_slots(input int n, input logic [15:0] v, input logic [3:0] d,
                            input logic hx, input logic ack_first);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      tb_idx = (tb_idx + 1) % 4;
      e.an  = 4'b0001 << tb_idx;
      e.seg = exp_seg(v, tb_idx, hx);
      e.dp  = d[tb_idx];
      e.fd  = (tb_idx == 0);
      e.ack = (k == 0) && ack_first;
      sb.push_back(e);
    end
  endtask

  function automatic exp_t reset_exp();
    exp_t e;
    e.an = 4'b0001; e.seg = 7'b1111110; e.dp = 1'b0; e.fd = 1'b0; e.ack = 1'b0;
    return e;
  endfunction

  // Wait for the negedge just before posedge number k (counted from reset release).
  task automatic goto(input int k);
    int g;
    g = 0;
    while (cyc < k - 1 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 1000) chk("goto_timeout", 32'(cyc), 32'(k - 1));
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
    load = 1'b1; value = v; dp_in = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_an"},  32'(an),         32'(4'b0001));
    chk({tag, "_seg"}, 32'(seg),        32'(7'b1111110));
    chk({tag, "_dp"},  32'(dp),         32'(1'b0));
    chk({tag, "_fd"},  32'(frame_done), 32'(1'b0));
    chk({tag, "_ack"}, 32'(load_ack),   32'(1'b0));
  endtask

  // Slot-boundary scoreboard compare, plus hold/no-pulse checks mid-slot.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      cyc++;
      if (cyc % 4 == 0 && sb.size() > 0) begin
        cur = sb.pop_front();
        chk("slot_an",  32'(an),         32'(cur.an));
        chk("slot_seg", 32'(seg),        32'(cur.seg));
        chk("slot_dp",  32'(dp),         32'(cur.dp));
        chk("slot_fd",  32'(frame_done), 32'(cur.fd));
        chk("slot_ack", 32'(load_ack),   32'(cur.ack));
      end else begin
        chk("hold_an",  32'(an),         32'(cur.an));
        chk("hold_seg", 32'(seg),        32'(cur.seg));
        chk("idle_fd",  32'(frame_done), 32'(1'b0));
        chk("idle_ack", 32'(load_ack),   32'(1'b0));
      end
    end
  end

  initial begin
    rst_n = 1'b0; load = 1'b0; value = 16'h0; dp_in = 4'h0; hex_mode = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");

    // Release; idle scan of zeros for a little over two frames.
    rst_n = 1'b1; cyc = 0; tb_idx = 0; cur = reset_exp();
    push_slots(9, 16'h0000, 4'h0, 1'b1, 1'b0);
    push_slots(2, 16'h0000, 4'h0, 1'b1, 1'b0);
    push_slots(4, 16'h1234, 4'h0, 1'b1, 1'b1);
    mon_en = 1'b1;

    // Mid-frame load: held back until the wrap at 48.
    goto(38);
    pulse_load(16'h1234, 4'h0);

    // Two loads in one frame: last wins, one ack at 80.
    push_slots(4, 16'h1234, 4'h0, 1'b1, 1'b0);
    push_slots(4, 16'h2222, 4'h0, 1'b1, 1'b1);
    goto(66);
    pulse_load(16'h1111, 4'h0);
    goto(70);
    pulse_load(16'h2222, 4'h0);

    // Load on the wrap-tick cycle commits on that edge.
    push_slots(4, 16'h5678, 4'b0010, 1'b1, 1'b1);
    goto(96);
    pulse_load(16'h5678, 4'b0010);
    dp_in = 4'h0;

    // Hex digits, then hex_mode off blanks them from the next frame.
    push_slots(4, 16'h00AF, 4'b0100, 1'b1, 1'b1);
    push_slots(4, 16'h00AF, 4'b0100, 1'b0, 1'b0);
    goto(110);
    pulse_load(16'h00AF, 4'b0100);
    goto(127);
    hex_mode = 1'b0;

    // Leading zeros (blank only when the option is built in).
    push_slots(4, 16'h0070, 4'h0, 1'b0, 1'b1);
    push_slots(2, 16'h0070, 4'h0, 1'b0, 1'b0);
    goto(142);
    pulse_load(16'h0070, 4'h0);

    // Reset mid-slot with a load pending: it must vanish.
    goto(162);
    pulse_load(16'h9999, 4'h0);
    goto(167);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    chk("sb_empty_at_rst", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; cyc = 0; tb_idx = 0; cur = reset_exp();
    push_slots(8, 16'h0000, 4'h0, 1'b0, 1'b0);
    mon_en = 1'b1;

    begin
      int g;
      g = 0;
      while (sb.size() > 0 && g < 200) begin
        @(negedge clk);
        g++;
      end
      if (g >= 200) chk("drain_timeout", 32'(sb.size()), 32'd0);
    end
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
